// File: rtl/bg_loader_pkg.sv
// Types and helpers for the background image loader's write port.
package bg_loader_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 12;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] pixel_t;
   typedef logic [3:0]        nibble_t;

   // 4-4-4 RGB: red nibble on top, green/blue byte taken verbatim from the stream.
   function automatic pixel_t pack_pixel(input nibble_t r, input logic [7:0] gb);
      return {r, gb};
   endfunction

endpackage

// File: rtl/vga_pkg.sv
// Display-wide constants shared by the background loader and the background drawing block.
package vga_pkg;

   localparam int BG_IMG_WIDTH  = 64;
   localparam int BG_IMG_HEIGHT = 48;

endpackage

// File: rtl/bg_loader_if.sv
// Byte-stream input, memory write port and load status of the background loader.
interface bg_loader_if;
   import bg_loader_pkg::*;

   logic       start;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       wr_en;
   addr_t      wr_addr;
   pixel_t     wr_data;
   logic       busy;
   logic       done;

   modport master (
      output start, in_data, in_valid,
      input  in_ready, wr_en, wr_addr, wr_data, busy, done
   );

   modport slave (
      input  start, in_data, in_valid,
      output in_ready, wr_en, wr_addr, wr_data, busy, done
   );

endinterface

// File: rtl/bg_loader.sv
// Loads a full background image from a byte stream (two bytes per pixel) into
// the consumer's background memory, one row-major write per pixel.
module bg_loader
   import vga_pkg::*;
   import bg_loader_pkg::*;
#(
   parameter int IMG_W = BG_IMG_WIDTH,
   parameter int IMG_H = BG_IMG_HEIGHT
)(
   input  logic      clk,
   input  logic      rst,
   bg_loader_if.slave bus
);

   localparam int PIXELS = IMG_W * IMG_H;

   typedef enum logic [1:0] {
      IDLE,
      RX_HI,
      RX_LO,
      FINISH
   } state_t;

   state_t  state;
   state_t  next_state;
   addr_t   count;
   nibble_t r_nib;
   logic    accept;
   logic    restart;
   logic    last;

   assign accept  = bus.in_valid && bus.in_ready;
   assign restart = bus.start && (state != FINISH);
   assign last    = (count == addr_t'(PIXELS - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (bus.start) next_state = RX_HI;
         end
         RX_HI: begin
            if (bus.start)   next_state = RX_HI;
            else if (accept) next_state = RX_LO;
         end
         RX_LO: begin
            if (bus.start)   next_state = RX_HI;
            else if (accept) next_state = last ? FINISH : RX_HI;
         end
         FINISH: begin
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // A start in either receive state wins over a byte arriving that cycle.
   always_comb begin
      bus.in_ready = ((state == RX_HI) || (state == RX_LO)) && !bus.start;
      bus.busy     = (state == RX_HI) || (state == RX_LO);
      bus.done     = (state == FINISH);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count       <= '0;
         r_nib       <= '0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
      end else begin
         bus.wr_en <= 1'b0;
         if (restart) begin
            count <= '0;
            r_nib <= '0;
         end else if ((state == RX_HI) && accept) begin
            r_nib <= bus.in_data[3:0];
         end else if ((state == RX_LO) && accept) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= count;
            bus.wr_data <= pack_pixel(r_nib, bus.in_data);
            // The counter parks on the final address; FINISH ends the load.
            if (!last) count <= count + addr_t'(1);
         end
      end
   end

endmodule

// File: tb/tb_bg_loader.sv
// Scoreboard bench for bg_loader: expected writes are queued by the stimulus and
// popped by a negedge monitor whenever the loader strobes wr_en.
`timescale 1ns/1ps
module tb_bg_loader;
   import bg_loader_pkg::*;

   localparam int W      = 64;
   localparam int H      = 48;
   localparam int PIXELS = W * H;

   typedef struct packed {
      addr_t  addr;
      pixel_t data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   bg_loader_if bus();

   bg_loader #(.IMG_W(W), .IMG_H(H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   wr_t   exp_q[$];
   int    passed      = 0;
   int    total       = 0;
   int    write_count = 0;
   int    done_count  = 0;
   int    next_addr   = 0;
   addr_t last_addr   = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      check({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
      check({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
      check({tag, "_wr_data"},  32'(bus.wr_data),  32'd0);
      check({tag, "_busy"},     32'(bus.busy),     32'd0);
      check({tag, "_done"},     32'(bus.done),     32'd0);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
   endtask

   // Callers are always positioned 1ns after a rising edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      logic ok;
      bus.in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo, input int gap);
      wr_t e;
      send_byte(hi, gap);
      e.addr = addr_t'(next_addr);
      e.data = {hi[3:0], lo};
      exp_q.push_back(e);
      next_addr++;
      send_byte(lo, gap);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      next_addr = 0;
   endtask

   always @(negedge clk) begin
      if (bus.wr_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(bus.wr_addr), 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
            check("wr_data", 32'(bus.wr_data), 32'(e.data));
         end
         last_addr = bus.wr_addr;
         write_count++;
      end
      if (bus.done) begin
         done_count++;
         check("done_after_last_addr", 32'(last_addr), 32'(PIXELS - 1));
         check("busy_low_with_done",   32'(bus.busy),  32'd0);
      end
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] hi;
      logic [7:0] lo;
      bus.start    = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_idle("por");
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] single pixel");
      pulse_start();
      send_pixel(8'hA5, 8'h3C, 0);
      @(negedge clk);
      check("single_wr_en_latency", 32'(bus.wr_en), 32'd1);
      @(negedge clk);
      check("single_wr_en_one_cycle", 32'(bus.wr_en),   32'd0);
      check("single_addr_hold",       32'(bus.wr_addr), 32'h000);
      check("single_data_hold",       32'(bus.wr_data), 32'h53C);

      $display("[TB] reset mid-load");
      @(posedge clk);
      #1;
      send_byte(8'h77, 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("midload_rst");
      rst = 1'b1;
      bus.in_data  = 8'h12;
      bus.in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_ignores_bytes", 32'(bus.in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;

      $display("[TB] restart after 100 pixels");
      pulse_start();
      for (int i = 0; i < 100; i++) begin
         hi = 8'(i);
         lo = 8'(i * 3);
         send_pixel(hi, lo, i % 2);
      end
      send_byte(8'h4B, 0);
      pulse_start();
      send_pixel(8'h17, 8'h9E, 0);

      $display("[TB] start collides with byte in RX_LO");
      send_byte(8'h6D, 0);
      bus.start    = 1'b1;
      bus.in_data  = 8'hFF;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("collide_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      next_addr    = 0;
      @(negedge clk);
      check("collide_no_write", 32'(bus.wr_en), 32'd0);
      check("collide_busy",     32'(bus.busy),  32'd1);
      @(posedge clk);
      #1;
      send_pixel(8'h02, 8'h11, 0);

      $display("[TB] full image load");
      @(posedge clk);
      #1;
      pulse_start();
      write_count = 0;
      done_count  = 0;
      for (int i = 0; i < PIXELS; i++) begin
         hi = 8'($urandom_range(0, 255));
         lo = 8'($urandom_range(0, 255));
         send_pixel(hi, lo, int'($urandom_range(0, 2)));
      end
      bus.start = 1'b1;
      @(negedge clk);
      check("finish_done",      32'(bus.done), 32'd1);
      check("finish_busy_low",  32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("after_finish_busy",     32'(bus.busy),     32'd0);
      check("after_finish_done",     32'(bus.done),     32'd0);
      check("after_finish_in_ready", 32'(bus.in_ready), 32'd0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("full_write_count", 32'(write_count), 32'(PIXELS));
      check("full_done_count",  32'(done_count),  32'd1);
      check("full_last_addr",   32'(last_addr),   32'(PIXELS - 1));
      check("exp_queue_empty",  32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bg_loader.md
BG_LOADER -- requirements
Module: bg_loader

Interface
REQ-001 SHALL have parameter IMG_W, default 64, meaning background image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 48, meaning background image height in pixels.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse beginning a full-image load.
REQ-006 SHALL have port in_data  input  8  incoming byte from the byte-stream source.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port wr_en  output  1  background memory write strobe.
REQ-010 SHALL have port wr_addr  output  12  pixel address, row-major (y*IMG_W + x).
REQ-011 SHALL have port wr_data  output  12  pixel colour, 4-4-4 RGB, R in [11:8].
REQ-012 SHALL have port busy  output  1  load in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the last pixel is written.

Function
REQ-014 SHALL implement states IDLE, RX_HI, RX_LO, FINISH.
REQ-015 SHALL accept a byte only on a cycle with in_valid=1 and in_ready=1.
REQ-016 SHALL drive in_ready=1 only in RX_HI or RX_LO with start=0 (combinational from state and start).
REQ-017 SHALL, in IDLE on start=1, clear the pixel counter to 0, set busy=1, and enter RX_HI next cycle.
REQ-018 SHALL, in RX_HI on an accepted byte, latch in_data[3:0] as R, discard in_data[7:4], and enter RX_LO.
REQ-019 SHALL, in RX_LO on an accepted byte, register wr_en=1, wr_data={R, in_data[7:0]}, wr_addr=pixel counter on the next clock edge (latency 1 cycle).
REQ-020 SHALL hold wr_en high for exactly one cycle per pixel; wr_addr/wr_data hold their last values while wr_en=0.
REQ-021 SHALL, after a pixel accept with counter < IMG_W*IMG_H-1, increment the counter and return to RX_HI.
REQ-022 SHALL, after a pixel accept with counter = IMG_W*IMG_H-1 (3071 by default), enter FINISH; the counter does not wrap.
REQ-023 SHALL in FINISH assert done=1 for one cycle, clear busy on that same cycle, and enter IDLE next cycle.
REQ-024 SHALL, on start=1 in RX_HI or RX_LO, discard any partial pixel, clear the counter to 0, and enter RX_HI; no byte is accepted that cycle.
REQ-025 SHALL ignore start in FINISH.
REQ-026 SHALL tolerate in_valid deasserted for any number of cycles in RX states without state change.
REQ-027 SHALL write addresses strictly sequentially 0..IMG_W*IMG_H-1 within one load.

Reset
REQ-028 SHALL on rst=0 at a clock edge force state IDLE, counter 0, latched R 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0.
REQ-029 SHALL, on reset mid-load, abandon the load with no further write and no done pulse.

Structure
REQ-030 SHALL take BG_IMG_WIDTH (64) and BG_IMG_HEIGHT (48) from vga_pkg as parameter defaults, shared with the background drawing block.
REQ-031 SHALL keep the state enum typedef local to the module.
REQ-032 SHALL be a single module with no sub-modules; the memory it writes lives in the consumer.

Verification
REQ-033 SHALL verify reset: rst=0 for 3 cycles mid-load -> all outputs 0, state IDLE, no wr_en.
REQ-034 SHALL verify a single pixel: start, bytes 0xA5, 0x3C -> wr_en one cycle later with wr_addr=0, wr_data=0x53C.
REQ-035 SHALL verify a full load: 6144 bytes with random in_valid gaps -> 3072 writes at addresses 0..3071, done pulses once after address 3071, busy falls with done.
REQ-036 SHALL verify restart: start after 100 pixels plus one high byte -> next write at address 0 using only subsequent bytes.
REQ-037 SHALL verify simultaneous start and in_valid in RX_LO -> in_ready=0, byte not consumed, no write, next state RX_HI.
REQ-038 SHALL verify that start during FINISH is ignored -> done pulses once, then IDLE with busy=0.
